// File: rtl/pool1_window_reader_pkg.sv
// Shared constants, types and helpers for the pool1 window reader.
// The conv1 map is walked in 2x2 windows; OUT_DIM is the pooled side length.
package pool1_pkg;
  localparam int DATA_W     = 16;
  localparam int IN_DIM     = 24;
  localparam int ADDR_W     = 10;
  localparam int OUT_ADDR_W = 8;
  localparam int OUT_DIM    = IN_DIM / 2;
  localparam int IDX_W      = $clog2(OUT_DIM);

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, DONE} state_e;

  // Offset of the k-th element of a 2x2 window from its top-left address.
  function automatic logic [ADDR_W-1:0] rd_offset(input logic [1:0] k);
    case (k)
      2'd0:    rd_offset = '0;
      2'd1:    rd_offset = ADDR_W'(1);
      2'd2:    rd_offset = ADDR_W'(IN_DIM);
      default: rd_offset = ADDR_W'(IN_DIM + 1);
    endcase
  endfunction
endpackage

// File: rtl/pool1_window_reader_if.sv
// Read port to the conv1 memory and valid/ready output port to the pool1 writer.
interface pool1_window_reader_if;
  import pool1_pkg::*;

  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_en;
  data_t                 rd_data;
  data_t                 out_data;
  logic [OUT_ADDR_W-1:0] out_addr;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output rd_addr, rd_en, out_data, out_addr, out_valid,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_addr, rd_en, out_data, out_addr, out_valid,
    output rd_data, out_ready
  );
endinterface

// File: rtl/pool1_window_reader_pool_max_unit.sv
// Registered signed max accumulator: load overwrites, cmp keeps the strictly larger value.
module pool_max_unit
  import pool1_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_reset,
  input  logic  i_load,
  input  logic  i_cmp,
  input  data_t i_data,
  output data_t o_max
);
  data_t r_max;

  always_ff @(posedge i_clk) begin
    if (i_reset)                          r_max <= '0;
    else if (i_load)                      r_max <= i_data;
    else if (i_cmp && (i_data > r_max))   r_max <= i_data;
  end

  assign o_max = r_max;
endmodule

// File: rtl/pool1_window_reader.sv
// Walks the conv1 map in 2x2 windows, reads each window and emits its signed maximum.
//   state | meaning
//   IDLE  | waiting for i_enable
//   READ  | issuing the 4 window reads (r_k = 0..3)
//   DRAIN | last datum returning from memory
//   EMIT  | pooled value offered until accepted
//   DONE  | all windows emitted, sticky until reset
module pool1_window_reader
  import pool1_pkg::*;
#(
  parameter logic [pool1_pkg::ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_done,
  pool1_window_reader_if.master bus
);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OUT_DIM - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IN_DIM);

  state_e                r_state;
  logic [1:0]            r_k;
  logic [IDX_W-1:0]      r_pr, r_pc;
  logic [ADDR_W-1:0]     r_row_base, r_col_off, r_rd_addr;
  logic                  r_rd_en, r_out_valid, r_done;
  logic [OUT_ADDR_W-1:0] r_out_addr;

  logic                  w_last_col, w_last_win, w_load, w_cmp;
  logic [ADDR_W-1:0]     w_win_base, w_next_row_base, w_next_col_off;
  data_t                 w_max;

  assign w_win_base      = r_row_base + r_col_off;
  assign w_last_col      = (r_pc == LAST_IDX);
  assign w_last_win      = w_last_col && (r_pr == LAST_IDX);
  assign w_next_row_base = w_last_col ? r_row_base + ROW_STEP : r_row_base;
  assign w_next_col_off  = w_last_col ? '0 : r_col_off + ADDR_W'(2);

  // Data for issue k lands one cycle later, i.e. while r_k = k+1 (or in DRAIN for k=3).
  assign w_load = (r_state == READ) && (r_k == 2'd1);
  assign w_cmp  = ((r_state == READ) && (r_k >= 2'd2)) || (r_state == DRAIN);

  pool_max_unit u_max (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_cmp   (w_cmp),
    .i_data  (bus.rd_data),
    .o_max   (w_max)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_pr        <= '0;
      r_pc        <= '0;
      r_row_base  <= BASE_ADDR;
      r_col_off   <= '0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state   <= READ;
            r_k       <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= w_win_base;
          end
        end
        READ: begin
          if (r_k == 2'd3) begin
            r_state <= DRAIN;
            r_rd_en <= 1'b0;
          end else begin
            r_k       <= r_k + 2'd1;
            r_rd_addr <= w_win_base + rd_offset(r_k + 2'd1);
          end
        end
        DRAIN: begin
          r_state     <= EMIT;
          r_out_valid <= 1'b1;
        end
        EMIT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_win) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= READ;
              r_k        <= '0;
              r_pc       <= w_last_col ? '0 : r_pc + IDX_W'(1);
              r_pr       <= w_last_col ? r_pr + IDX_W'(1) : r_pr;
              r_row_base <= w_next_row_base;
              r_col_off  <= w_next_col_off;
              r_out_addr <= r_out_addr + OUT_ADDR_W'(1);
              r_rd_en    <= 1'b1;
              r_rd_addr  <= w_next_row_base + w_next_col_off;
            end
          end
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd_addr   = r_rd_addr;
  assign bus.rd_en     = r_rd_en;
  assign bus.out_data  = w_max;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_valid = r_out_valid;
  assign o_done        = r_done;
endmodule

// File: tb/tb_pool1_window_reader.sv
// Directed bench for pool1_window_reader with a 1-cycle-latency memory model.
module tb_pool1_window_reader;
  import pool1_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic done;
  int   n_asserts = 0;
  int   n_fail = 0;
  data_t mem [0:IN_DIM*IN_DIM-1];

  pool1_window_reader_if bus ();

  pool1_window_reader dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_enable (enable),
    .o_done   (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 0);
    chk({tag, "_out_addr"}, 32'(bus.out_addr), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  function automatic int exp_addr(input int r);
    int w, k, base;
    w = r / 4;
    k = r % 4;
    base = 2 * (w / OUT_DIM) * IN_DIM + 2 * (w % OUT_DIM);
    case (k)
      0: return base;
      1: return base + 1;
      2: return base + IN_DIM;
      default: return base + IN_DIM + 1;
    endcase
  endfunction

  initial begin
    int c, r, n, t;
    bit seen_done;
    for (int i = 0; i < IN_DIM*IN_DIM; i++) mem[i] = data_t'(i);
    bus.out_ready = 1'b1;

    // Reset state
    do_reset();
    #1;
    chk_idle_outputs("reset");

    // Window (0,0) and all-negative window (0,1) with backpressure
    mem[0] = 16'sd5;   mem[1] = -16'sd3;  mem[24] = 16'sd9;  mem[25] = 16'sd2;
    mem[2] = -16'sd7;  mem[3] = -16'sd2;  mem[26] = -16'sd9; mem[27] = -16'sd2;
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("w0_rd_en0", 32'(bus.rd_en), 1);
    chk("w0_addr0", 32'(bus.rd_addr), 0);
    step(); chk("w0_addr1", 32'(bus.rd_addr), 1);
    step(); chk("w0_addr2", 32'(bus.rd_addr), 24);
    step(); chk("w0_addr3", 32'(bus.rd_addr), 25);
    chk("w0_rd_en3", 32'(bus.rd_en), 1);
    step();
    chk("w0_drain_rd_en", 32'(bus.rd_en), 0);
    chk("w0_drain_valid", 32'(bus.out_valid), 0);
    step();
    chk("w0_valid", 32'(bus.out_valid), 1);
    chk("w0_data", 32'(bus.out_data), 32'(9));
    chk("w0_oaddr", 32'(bus.out_addr), 0);
    step();
    chk("w0_valid_drop", 32'(bus.out_valid), 0);
    chk("w1_addr0", 32'(bus.rd_addr), 2);
    bus.out_ready = 1'b0;
    enable = 1'b1;
    step(); chk("w1_addr1", 32'(bus.rd_addr), 3);
    step(); chk("w1_addr2", 32'(bus.rd_addr), 26);
    step(); chk("w1_addr3", 32'(bus.rd_addr), 27);
    enable = 1'b0;
    step();
    step();
    chk("w1_valid", 32'(bus.out_valid), 1);
    chk("w1_data_neg", 32'(bus.out_data), 32'(-2));
    chk("w1_oaddr", 32'(bus.out_addr), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_data", 32'(bus.out_data), 32'(-2));
      chk("stall_oaddr", 32'(bus.out_addr), 1);
      chk("stall_rd_en", 32'(bus.rd_en), 0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("w2_rd_en", 32'(bus.rd_en), 1);
    chk("w2_addr0", 32'(bus.rd_addr), 4);
    chk("w2_valid_low", 32'(bus.out_valid), 0);

    // Reset during READ k=2 of window 37, then restart from (0,0)
    for (int i = 0; i < IN_DIM*IN_DIM; i++) mem[i] = data_t'(i);
    do_reset();
    enable = 1'b1;
    step();
    enable = 1'b0;
    t = 0;
    while (!(bus.rd_en === 1'b1 && bus.rd_addr === ADDR_W'(170)) && t < 400) begin
      step();
      t++;
    end
    chk("w37_reached", 32'(t < 400), 1);
    reset = 1'b1;
    step();
    chk_idle_outputs("midreset");
    reset = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("restart_rd_en", 32'(bus.rd_en), 1);
    chk("restart_addr", 32'(bus.rd_addr), 0);
    for (int i = 0; i < 5; i++) step();
    chk("restart_valid", 32'(bus.out_valid), 1);
    chk("restart_data", 32'(bus.out_data), 32'(25));
    chk("restart_oaddr", 32'(bus.out_addr), 0);

    // Full map run with out_ready high
    do_reset();
    enable = 1'b1;
    step();
    enable = 1'b0;
    c = 0; r = 0; n = 0; seen_done = 1'b0;
    while (c <= 2000) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
        chk("done_cycle", 32'(c), 32'(864));
        break;
      end
      if (bus.rd_en === 1'b1) begin
        chk("full_rd_addr", 32'(bus.rd_addr), 32'(exp_addr(r)));
        r++;
      end
      if (bus.out_valid === 1'b1) begin
        chk("full_oaddr", 32'(bus.out_addr), 32'(n));
        chk("full_data", 32'(bus.out_data), 32'(exp_addr(4*n) + IN_DIM + 1));
        n++;
      end
      step();
      c++;
    end
    chk("full_done_seen", 32'(seen_done), 1);
    chk("full_reads", 32'(r), 32'(576));
    chk("full_outputs", 32'(n), 32'(144));
    chk("last_oaddr", 32'(bus.out_addr), 32'(143));
    for (int i = 0; i < 6; i++) begin
      enable = ~enable;
      step();
      chk("done_sticky", 32'(done), 1);
      chk("done_rd_en", 32'(bus.rd_en), 0);
      chk("done_valid", 32'(bus.out_valid), 0);
    end
    enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
